// File: rtl/urv_decode_if.sv
// urv_decode_if: fetch-to-decode and decode-to-execute signal bundle
interface urv_decode_if;
   logic        f_valid_i;
   logic [31:0] f_ir_i;
   logic [31:0] f_pc_i;
   logic        x_stall_i;
   logic        x_kill_i;
   logic        d_stall_req_o;
   logic [4:0]  rf_rs1_o;
   logic [4:0]  rf_rs2_o;
   logic        d_valid_o;
   logic [31:0] d_pc_o;
   logic [31:0] d_ir_o;
   logic [4:0]  d_opcode_o;
   logic [2:0]  d_fun3_o;
   logic [6:0]  d_fun7_o;
   logic [4:0]  d_rs1_o;
   logic [4:0]  d_rs2_o;
   logic [4:0]  d_rd_o;
   logic [31:0] d_imm_o;
   logic        d_rd_write_o;
   logic        d_is_load_o;
   logic        d_is_store_o;
   logic        d_is_branch_o;
   logic        d_illegal_o;
   modport master (
      input  f_valid_i, f_ir_i, f_pc_i, x_stall_i, x_kill_i,
      output d_stall_req_o, rf_rs1_o, rf_rs2_o, d_valid_o, d_pc_o, d_ir_o,
             d_opcode_o, d_fun3_o, d_fun7_o, d_rs1_o, d_rs2_o, d_rd_o, d_imm_o,
             d_rd_write_o, d_is_load_o, d_is_store_o, d_is_branch_o, d_illegal_o
   );
   modport slave (
      output f_valid_i, f_ir_i, f_pc_i, x_stall_i, x_kill_i,
      input  d_stall_req_o, rf_rs1_o, rf_rs2_o, d_valid_o, d_pc_o, d_ir_o,
             d_opcode_o, d_fun3_o, d_fun7_o, d_rs1_o, d_rs2_o, d_rd_o, d_imm_o,
             d_rd_write_o, d_is_load_o, d_is_store_o, d_is_branch_o, d_illegal_o
   );
endinterface

// File: rtl/urv_decode.sv
// urv_decode: RV32I decode stage with load-use interlock and branch kill
module urv_decode #(
   parameter bit g_with_load_interlock = 1'b1,
   parameter bit g_check_illegal       = 1'b1
) (
   input logic          clk_i,
   input logic          rst_i,
   urv_decode_if.master bus
);
   logic [31:0] ir;
   logic [6:0]  op;
   logic [4:0]  rs1, rs2, rd;
   logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
   logic is_opimm, is_op, is_misc, is_system;
   logic uses_rs1, uses_rs2, legal, rd_write, hazard;
   logic [31:0] imm;

   assign ir  = bus.f_ir_i;
   assign op  = ir[6:0];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign rd  = ir[11:7];
   assign bus.rf_rs1_o = rs1;
   assign bus.rf_rs2_o = rs2;

   // Classify the fetched word, build its immediate and detect load-use against the decode register
   always_comb begin
      is_lui    = op == 7'b0110111;
      is_auipc  = op == 7'b0010111;
      is_jal    = op == 7'b1101111;
      is_jalr   = op == 7'b1100111;
      is_branch = op == 7'b1100011;
      is_load   = op == 7'b0000011;
      is_store  = op == 7'b0100011;
      is_opimm  = op == 7'b0010011;
      is_op     = op == 7'b0110011;
      is_misc   = op == 7'b0001111;
      is_system = op == 7'b1110011;
      legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store
                | is_opimm | is_op | is_misc | is_system;
      uses_rs1  = is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
      uses_rs2  = is_branch | is_store | is_op;
      rd_write  = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op) & (rd != 5'd0);
      imm = (is_jalr | is_load | is_opimm) ? {{20{ir[31]}}, ir[31:20]} :
            is_store                       ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
            is_branch                      ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
            (is_lui | is_auipc)            ? {ir[31:12], 12'b0} :
            is_jal                         ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                                             32'd0;
      hazard = g_with_load_interlock && bus.d_valid_o && bus.d_is_load_o && (bus.d_rd_o != 5'd0)
             && bus.f_valid_i && ((uses_rs1 && rs1 == bus.d_rd_o) || (uses_rs2 && rs2 == bus.d_rd_o));
      bus.d_stall_req_o = bus.x_stall_i | (hazard & ~bus.x_kill_i);
   end

   // Decode pipeline register: load on advance, hold on stall, kill always clears valid
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.d_valid_o     <= 1'b0;
         bus.d_pc_o        <= '0;
         bus.d_ir_o        <= '0;
         bus.d_opcode_o    <= '0;
         bus.d_fun3_o      <= '0;
         bus.d_fun7_o      <= '0;
         bus.d_rs1_o       <= '0;
         bus.d_rs2_o       <= '0;
         bus.d_rd_o        <= '0;
         bus.d_imm_o       <= '0;
         bus.d_rd_write_o  <= 1'b0;
         bus.d_is_load_o   <= 1'b0;
         bus.d_is_store_o  <= 1'b0;
         bus.d_is_branch_o <= 1'b0;
         bus.d_illegal_o   <= 1'b0;
      end else if (!bus.x_stall_i) begin
         bus.d_valid_o     <= bus.f_valid_i & ~hazard & ~bus.x_kill_i;
         bus.d_pc_o        <= bus.f_pc_i;
         bus.d_ir_o        <= ir;
         bus.d_opcode_o    <= ir[6:2];
         bus.d_fun3_o      <= ir[14:12];
         bus.d_fun7_o      <= ir[31:25];
         bus.d_rs1_o       <= rs1;
         bus.d_rs2_o       <= rs2;
         bus.d_rd_o        <= rd;
         bus.d_imm_o       <= imm;
         bus.d_rd_write_o  <= rd_write;
         bus.d_is_load_o   <= is_load;
         bus.d_is_store_o  <= is_store;
         bus.d_is_branch_o <= is_branch;
         bus.d_illegal_o   <= g_check_illegal ? ~legal : 1'b0;
      end else if (bus.x_kill_i) begin
         bus.d_valid_o     <= 1'b0;
      end
   end
endmodule
